adc_serial_emul: RTL and testbench

//  Transmit-side emulator of the multi-channel serial ADC link: serialises parallel 12-bit samples onto

---
 rtl/adc_serial_emul.sv | 167 ++++++++++++++++
 tb/tb_adc_serial_emul.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/adc_serial_emul.sv
// adc_serial_emul: serialises CHAN parallel WIDTH-bit samples MSB first with bit clock and word frame.
// Latency: MSB on adc_data_p the cycle after LOAD; word = WIDTH*2*DIV cycles plus one LOAD cycle.
// Backpressure: sample_ready strobes once per word; missing sample_valid replays the last word (underrun).
// Optional feature: define ADC_RAMP_EN to add the internal per-lane ramp source selected by ramp_mode.
module adc_serial_emul #(
   parameter int CHAN  = 8,
   parameter int WIDTH = 12,
   parameter int DIV   = 2
) (
   input  logic                  CK50,
   input  logic                  RST_n,
   input  logic                  tx_en,
   input  logic                  ramp_mode,
   input  logic [CHAN*WIDTH-1:0] sample_in,
   input  logic                  sample_valid,
   output logic                  sample_ready,
   output logic [CHAN-1:0]       adc_data_p,
   output logic                  adc_clk,
   output logic                  adc_frame,
   output logic [15:0]           word_cnt,
   output logic                  underrun
);
   localparam int PW = (2*DIV > 2) ? $clog2(2*DIV) : 1;
   localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [PW-1:0] PH_HALF  = PW'(DIV);
   localparam logic [PW-1:0] PH_LAST  = PW'(2*DIV-1);
   localparam logic [BW-1:0] BIT_MSB  = BW'(WIDTH-1);
   localparam logic [BW-1:0] BIT_HALF = BW'(WIDTH/2);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

   state_t                state_q, state_d;
   logic [PW-1:0]         ph_q, ph_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic [CHAN*WIDTH-1:0] shift_q, shift_d;
   logic [CHAN*WIDTH-1:0] last_q, last_d;
   logic [CHAN*WIDTH-1:0] new_word;
   logic [CHAN-1:0]       data_q, data_d;
   logic                  frame_q, frame_d;
   logic                  clk_q, clk_d;
   logic [15:0]           cnt_q, cnt_d;
   logic                  underrun_q, underrun_d;
   logic                  use_ramp;
   logic [CHAN*WIDTH-1:0] ramp_word;

`ifdef ADC_RAMP_EN
   logic [WIDTH-1:0] ramp_q, ramp_d;

   assign use_ramp = ramp_mode;

   // Per-lane ramp word: lane i carries ramp + i, wrapping at WIDTH bits.
   always_comb begin
      ramp_word = '0;
      for (int i = 0; i < CHAN; i++) begin
         ramp_word[i*WIDTH +: WIDTH] = ramp_q + WIDTH'(i);
      end
      ramp_d = (state_q == S_LOAD) ? ramp_q + 1'b1 : ramp_q;
   end

   // Ramp base register, advanced once per LOAD cycle.
   always_ff @(posedge CK50) begin
      if (!RST_n) ramp_q <= '0;
      else        ramp_q <= ramp_d;
   end
`else
   logic unused_ramp_mode;
   assign unused_ramp_mode = ramp_mode;
   assign use_ramp         = 1'b0;
   assign ramp_word        = '0;
`endif

   // Next-state and output logic; data/frame are staged so each bit is stable for its full period.
   always_comb begin
      state_d      = state_q;
      ph_d         = ph_q;
      bit_d        = bit_q;
      shift_d      = shift_q;
      last_d       = last_q;
      data_d       = data_q;
      frame_d      = frame_q;
      cnt_d        = cnt_q;
      underrun_d   = underrun_q;
      new_word     = last_q;
      sample_ready = 1'b0;
      case (state_q)
         S_IDLE: begin
            data_d  = '0;
            frame_d = 1'b0;
            if (tx_en) state_d = S_LOAD;
         end
         S_LOAD: begin
            sample_ready = !use_ramp;
            if (use_ramp) begin
               new_word = ramp_word;
            end else if (sample_valid) begin
               new_word = sample_in;
               last_d   = sample_in;
            end else begin
               underrun_d = 1'b1;
            end
            shift_d = new_word;
            ph_d    = '0;
            bit_d   = BIT_MSB;
            for (int i = 0; i < CHAN; i++) begin
               data_d[i] = new_word[i*WIDTH + WIDTH - 1];
            end
            frame_d = 1'b1;
            state_d = S_RUN;
         end
         S_RUN: begin
            if (ph_q == PH_LAST) begin
               ph_d = '0;
               if (bit_q != '0) begin
                  bit_d = bit_q - 1'b1;
                  for (int i = 0; i < CHAN; i++) begin
                     data_d[i] = shift_q[i*WIDTH + int'(bit_d)];
                  end
                  frame_d = (bit_d >= BIT_HALF);
               end else begin
                  cnt_d   = cnt_q + 16'd1;
                  data_d  = '0;
                  frame_d = 1'b0;
                  state_d = tx_en ? S_LOAD : S_IDLE;
               end
            end else begin
               ph_d = ph_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      clk_d = (state_d == S_RUN) && (ph_d >= PH_HALF);
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge CK50) begin
      if (!RST_n) begin
         state_q    <= S_IDLE;
         ph_q       <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         last_q     <= '0;
         data_q     <= '0;
         frame_q    <= 1'b0;
         clk_q      <= 1'b0;
         cnt_q      <= '0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ph_q       <= ph_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         last_q     <= last_d;
         data_q     <= data_d;
         frame_q    <= frame_d;
         clk_q      <= clk_d;
         cnt_q      <= cnt_d;
         underrun_q <= underrun_d;
      end
   end

   assign adc_data_p = data_q;
   assign adc_clk    = clk_q;
   assign adc_frame  = frame_q;
   assign word_cnt   = cnt_q;
   assign underrun   = underrun_q;

endmodule

// File: tb/tb_adc_serial_emul.sv
// Bench for adc_serial_emul (CHAN=8, WIDTH=12, DIV=2): directed word table plus reset/disable sequences.
// Deserialises every lane on the adc_clk rising edge and checks clock, frame and stability per cycle.
// Inputs driven 1 time unit after posedge; outputs sampled at the same point.
module tb_adc_serial_emul;
   localparam int CHAN  = 8;
   localparam int WIDTH = 12;
   localparam int NB    = CHAN*WIDTH;

   logic          CK50 = 1'b0;
   logic          RST_n;
   logic          tx_en;
   logic          ramp_mode;
   logic [NB-1:0] sample_in;
   logic          sample_valid;
   logic          sample_ready;
   logic [CHAN-1:0] adc_data_p;
   logic          adc_clk;
   logic          adc_frame;
   logic [15:0]   word_cnt;
   logic          underrun;

   int n_vec = 0;
   int n_err = 0;

   adc_serial_emul #(.CHAN(CHAN), .WIDTH(WIDTH), .DIV(2)) dut (
      .CK50(CK50), .RST_n(RST_n), .tx_en(tx_en), .ramp_mode(ramp_mode),
      .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
      .adc_data_p(adc_data_p), .adc_clk(adc_clk), .adc_frame(adc_frame),
      .word_cnt(word_cnt), .underrun(underrun)
   );

   always #5 CK50 = ~CK50;

   typedef struct {
      logic [NB-1:0] smp;
      logic          vld;
      logic [NB-1:0] exp_word;
      logic          exp_under;
      logic [15:0]   exp_cnt;
   } vec_t;

   vec_t vecs[6];

   task automatic tick();
      @(posedge CK50);
      #1;
   endtask

   task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [NB-1:0] mk(input logic [11:0] l0, l1, l2, l3, l4, l5, l6, l7);
      return {l7, l6, l5, l4, l3, l2, l1, l0};
   endfunction

   // Called in the LOAD cycle: present a word, then watch 48 RUN cycles.
   // en_off_k >= 0 drops tx_en after that cycle of the word.
   task automatic xfer(input logic [NB-1:0] smp, input logic vld, input int en_off_k,
                       output logic [NB-1:0] rx, output int perr);
      logic [CHAN-1:0] prev;
      int b;
      rx   = '0;
      perr = 0;
      prev = '0;
      sample_in    = smp;
      sample_valid = vld;
      for (int k = 0; k < 48; k++) begin
         tick();
         if (k == 0) begin
            sample_valid = 1'b1;
            sample_in    = ~smp;
         end
         b = 11 - k/4;
         if (adc_clk !== ((k % 4) >= 2)) perr++;
         if (adc_frame !== (b >= 6)) perr++;
         if (sample_ready !== 1'b0) perr++;
         if ((k % 4) != 0 && adc_data_p !== prev) perr++;
         prev = adc_data_p;
         if ((k % 4) == 2) begin
            for (int i = 0; i < CHAN; i++) rx[i*WIDTH + b] = adc_data_p[i];
         end
         if (k == en_off_k) tx_en = 1'b0;
      end
      sample_valid = 1'b0;
   endtask

   initial begin
      logic [NB-1:0] rx;
      logic [NB-1:0] w_a;
      logic [NB-1:0] w_b;
      int perr;
      int idle_err;

      RST_n = 1'b0; tx_en = 1'b1; ramp_mode = 1'b0; sample_in = '0; sample_valid = 1'b0;

      vecs[0] = '{mk(12'hA5C, 0, 0, 0, 0, 0, 0, 0), 1'b1, mk(12'hA5C, 0, 0, 0, 0, 0, 0, 0), 1'b0, 16'd1};
      vecs[1] = '{mk(12'h123, 12'h456, 12'h789, 12'hABC, 12'hDEF, 12'h001, 12'h800, 12'h7FF), 1'b1,
                  mk(12'h123, 12'h456, 12'h789, 12'hABC, 12'hDEF, 12'h001, 12'h800, 12'h7FF), 1'b0, 16'd2};
      vecs[2] = '{mk(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF), 1'b1,
                  mk(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF), 1'b0, 16'd3};
      vecs[3] = '{mk(12'h555, 12'hAAA, 12'hF0F, 12'h0F0, 12'hC33, 12'h3CC, 12'hE01, 12'h1FE), 1'b1,
                  mk(12'h555, 12'hAAA, 12'hF0F, 12'h0F0, 12'hC33, 12'h3CC, 12'hE01, 12'h1FE), 1'b0, 16'd4};
      vecs[4] = '{mk(12'hBAD, 12'hBAD, 12'hBAD, 12'hBAD, 12'hBAD, 12'hBAD, 12'hBAD, 12'hBAD), 1'b0,
                  mk(12'h555, 12'hAAA, 12'hF0F, 12'h0F0, 12'hC33, 12'h3CC, 12'hE01, 12'h1FE), 1'b1, 16'd5};
      vecs[5] = '{mk(12'h0FF, 12'hF00, 12'h00F, 12'h0F0, 12'h963, 12'h369, 12'h001, 12'hFFE), 1'b1,
                  mk(12'h0FF, 12'hF00, 12'h00F, 12'h0F0, 12'h963, 12'h369, 12'h001, 12'hFFE), 1'b1, 16'd6};

      // Reset held with tx_en high: everything quiet.
      repeat (3) tick();
      chk("reset_outputs", NB'({sample_ready, adc_data_p, adc_clk, adc_frame, word_cnt, underrun}), '0);
      RST_n = 1'b1;
      tick();
      chk("first_load_ready", NB'(sample_ready), NB'(1'b1));

      // Back-to-back table: each word lands 49 cycles after the previous LOAD.
      for (int v = 0; v < 6; v++) begin
         xfer(vecs[v].smp, vecs[v].vld, -1, rx, perr);
         chk($sformatf("v%0d_word", v), rx, vecs[v].exp_word);
         chk($sformatf("v%0d_pattern_errs", v), NB'(perr), '0);
         tick();
         chk($sformatf("v%0d_next_ready", v), NB'(sample_ready), NB'(1'b1));
         chk($sformatf("v%0d_word_cnt", v), NB'(word_cnt), NB'(vecs[v].exp_cnt));
         chk($sformatf("v%0d_underrun", v), NB'(underrun), NB'(vecs[v].exp_under));
      end

      // tx_en dropped in bit 5: the word still completes, then the link idles.
      w_a = mk(12'h3A7, 12'h1C2, 12'h0F0, 12'h808, 12'h7E7, 12'h111, 12'hC0C, 12'h2D4);
      xfer(w_a, 1'b1, 24, rx, perr);
      chk("dis_word", rx, w_a);
      chk("dis_pattern_errs", NB'(perr), '0);
      tick();
      chk("dis_word_cnt", NB'(word_cnt), NB'(16'd7));
      idle_err = 0;
      sample_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         if ({sample_ready, adc_data_p, adc_clk, adc_frame} !== '0) idle_err++;
         tick();
      end
      sample_valid = 1'b0;
      chk("idle_quiet_errs", NB'(idle_err), '0);
      chk("idle_word_cnt", NB'(word_cnt), NB'(16'd7));

      // Reset in bit 5 aborts at once.
      tx_en = 1'b1;
      tick();
      chk("reen_ready", NB'(sample_ready), NB'(1'b1));
      sample_in = w_a;
      sample_valid = 1'b1;
      repeat (25) tick();
      RST_n = 1'b0;
      tick();
      chk("midrst_outputs", NB'({sample_ready, adc_data_p, adc_clk, adc_frame, word_cnt, underrun}), '0);
      RST_n = 1'b1;
      sample_valid = 1'b0;
      tick();
      chk("post_rst_ready", NB'(sample_ready), NB'(1'b1));

      // Fresh word, then an underrun repeats it.
      w_b = mk(12'h6B1, 12'h000, 12'hFFF, 12'h5A5, 12'h0C3, 12'h924, 12'h3F0, 12'hA0A);
      xfer(w_b, 1'b1, -1, rx, perr);
      chk("pr_word", rx, w_b);
      tick();
      chk("pr_cnt_under", NB'({word_cnt, underrun}), NB'({16'd1, 1'b0}));
      xfer(~w_b, 1'b0, -1, rx, perr);
      chk("ur_repeat_word", rx, w_b);
      chk("ur_pattern_errs", NB'(perr), '0);
      tick();
      chk("ur_cnt_under", NB'({word_cnt, underrun}), NB'({16'd2, 1'b1}));

`ifdef ADC_RAMP_EN
      // Ramp source: lane i of word n carries n + i, no handshake, no underrun.
      RST_n = 1'b0;
      ramp_mode = 1'b1;
      tick();
      RST_n = 1'b1;
      tick();
      for (int n = 0; n < 3; n++) begin
         chk($sformatf("ramp%0d_ready", n), NB'(sample_ready), '0);
         xfer('0, 1'b0, -1, rx, perr);
         chk($sformatf("ramp%0d_lane0", n), NB'(rx[11:0]), NB'(n));
         chk($sformatf("ramp%0d_lane3", n), NB'(rx[47:36]), NB'(n + 3));
         tick();
         chk($sformatf("ramp%0d_underrun", n), NB'(underrun), '0);
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
